// File: rtl/yamin_biu_pkg.sv
// yamin_biu_pkg: BIU write-path types: response codes, write-ID count and the
// captured AW/W payload.
package yamin_biu_pkg;

    typedef yamin_pkg::size_t size_t;
    typedef yamin_pkg::attr_t attr_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } bresp_t;

    localparam int NUM_WIDS_C = 4;

    typedef struct packed {
        logic [31:0] addr;
        size_t       size;
        logic [2:0]  prot;
        logic        lock;
        attr_t       attrs;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_payload_t;

    function automatic logic [NUM_WIDS_C-1:0] wid_mask(input logic [1:0] wid);
        return 4'b0001 << wid;
    endfunction

endpackage

// File: rtl/yamin_pkg.sv
// yamin_pkg: core-wide access size and memory attribute types shared by the LSU,
// store buffer and BIU.
package yamin_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic shareable;
        logic allocate;
        logic cacheable;
        logic bufferable;
    } attr_t;

endpackage

// File: rtl/yamin_biu_wid_alloc.sv
// yamin_biu_wid_alloc: picks the lowest-index free write ID from a free bitmap.
module yamin_biu_wid_alloc
    import yamin_biu_pkg::*;
(
    input  logic [NUM_WIDS_C-1:0] free_i,
    output logic                  any_free_o,
    output logic [1:0]            idx_o
);
    always_comb begin
        any_free_o = |free_i;
        idx_o      = free_i[0] ? 2'd0 : free_i[1] ? 2'd1 : free_i[2] ? 2'd2 : 2'd3;
    end
endmodule

// File: rtl/yamin_biu_wr.sv
// yamin_biu_wr: accepts store-buffer write requests, drives AW/W with a per-request
// write ID and reports completions, bus faults and exclusive status from B.
module yamin_biu_wr
    import yamin_biu_pkg::*;
#(
    parameter int NUM_WIDS = NUM_WIDS_C
) (
    input  logic        clk,
    input  logic        csysreset_n,
    input  logic        stb_biu_write_req_i,
    input  logic [3:0]  stb_biu_write_slot_i,
    input  logic [31:0] stb_biu_slot0_addr_i,
    input  logic [31:0] stb_biu_slot1_addr_i,
    input  logic [31:0] stb_biu_slot2_addr_i,
    input  logic [31:0] stb_biu_slot3_addr_i,
    input  logic [31:0] stb_biu_write_data_i,
    input  logic [3:0]  stb_biu_write_wstrb_i,
    input  size_t       stb_biu_write_size_i,
    input  logic        stb_biu_write_priv_i,
    input  logic        stb_biu_write_ns_attr_i,
    input  logic        stb_biu_write_dbg_i,
    input  logic        stb_biu_write_strex_i,
    input  attr_t       stb_biu_write_attrs_i,
    output logic        biu_stb_write_ack_o,
    output logic [3:0]  biu_stb_valid_wids_o,
    output logic        aw_valid_o,
    input  logic        aw_ready_i,
    output logic [31:0] aw_addr_o,
    output logic [1:0]  aw_id_o,
    output size_t       aw_size_o,
    output logic [2:0]  aw_prot_o,
    output logic        aw_lock_o,
    output attr_t       aw_attrs_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic [31:0] w_data_o,
    output logic [3:0]  w_strb_o,
    input  logic        b_valid_i,
    input  logic [1:0]  b_id_i,
    input  bresp_t      b_resp_i,
    output logic        biu_imp_bus_fault_o,
    output logic        biu_dbg_bus_fault_o,
    output logic        biu_strex_done_o,
    output logic        biu_strex_fail_o
);
    if (NUM_WIDS != NUM_WIDS_C) begin : g_bad_num_wids
        $error("yamin_biu_wr supports only NUM_WIDS = 4");
    end

    logic        hold_valid_q, hold_valid_d, aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    wr_payload_t pay_q, pay_d;
    logic [1:0]  wid_q, wid_d, alloc_idx;
    logic [3:0]  out_q, out_d, dbg_q, dbg_d, strex_q, strex_d, alloc_mask, b_mask;
    logic        imp_q, imp_d, dbgf_q, dbgf_d, sdone_q, sdone_d, sfail_q, sfail_d;
    logic        alloc_any, ack, b_hit, b_err;
    logic [31:0] slot_addr;

    yamin_biu_wid_alloc u_alloc (
        .free_i     (~out_q),
        .any_free_o (alloc_any),
        .idx_o      (alloc_idx)
    );

    always_comb begin
        ack          = csysreset_n && stb_biu_write_req_i && !hold_valid_q && alloc_any;
        slot_addr    = ({32{stb_biu_write_slot_i[0]}} & stb_biu_slot0_addr_i)
                     | ({32{stb_biu_write_slot_i[1]}} & stb_biu_slot1_addr_i)
                     | ({32{stb_biu_write_slot_i[2]}} & stb_biu_slot2_addr_i)
                     | ({32{stb_biu_write_slot_i[3]}} & stb_biu_slot3_addr_i);
        alloc_mask   = ack ? wid_mask(alloc_idx) : 4'b0000;
        b_hit        = b_valid_i && out_q[b_id_i];
        b_mask       = b_hit ? wid_mask(b_id_i) : 4'b0000;
        b_err        = (b_resp_i == SLVERR) || (b_resp_i == DECERR);
        aw_pend_d    = ack || (aw_pend_q && !aw_ready_i);
        w_pend_d     = ack || (w_pend_q && !w_ready_i);
        hold_valid_d = aw_pend_d || w_pend_d;
        wid_d        = ack ? alloc_idx : wid_q;
        pay_d        = ack ? wr_payload_t'{
                           addr:  slot_addr,
                           size:  stb_biu_write_size_i,
                           prot:  {1'b0, stb_biu_write_ns_attr_i, stb_biu_write_priv_i},
                           lock:  stb_biu_write_strex_i,
                           attrs: stb_biu_write_attrs_i,
                           data:  stb_biu_write_data_i,
                           strb:  stb_biu_write_wstrb_i} : pay_q;
        // Retire before allocate: a retiring ID is only offered again next cycle.
        out_d        = (out_q & ~b_mask) | alloc_mask;
        dbg_d        = (dbg_q & ~alloc_mask) | ({4{stb_biu_write_dbg_i}} & alloc_mask);
        strex_d      = (strex_q & ~alloc_mask) | ({4{stb_biu_write_strex_i}} & alloc_mask);
        imp_d        = b_hit && b_err && !dbg_q[b_id_i];
        dbgf_d       = b_hit && b_err && dbg_q[b_id_i];
        sdone_d      = b_hit && strex_q[b_id_i];
        sfail_d      = sdone_d && (b_resp_i != EXOKAY);
    end

    always_ff @(posedge clk) begin
        if (!csysreset_n) begin
            hold_valid_q <= 1'b0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            pay_q        <= '0;
            wid_q        <= 2'd0;
            out_q        <= 4'b0000;
            dbg_q        <= 4'b0000;
            strex_q      <= 4'b0000;
            imp_q        <= 1'b0;
            dbgf_q       <= 1'b0;
            sdone_q      <= 1'b0;
            sfail_q      <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            pay_q        <= pay_d;
            wid_q        <= wid_d;
            out_q        <= out_d;
            dbg_q        <= dbg_d;
            strex_q      <= strex_d;
            imp_q        <= imp_d;
            dbgf_q       <= dbgf_d;
            sdone_q      <= sdone_d;
            sfail_q      <= sfail_d;
        end
    end

    assign biu_stb_write_ack_o  = ack;
    assign biu_stb_valid_wids_o = out_q;
    assign aw_valid_o           = aw_pend_q;
    assign aw_addr_o            = pay_q.addr;
    assign aw_id_o              = wid_q;
    assign aw_size_o            = pay_q.size;
    assign aw_prot_o            = pay_q.prot;
    assign aw_lock_o            = pay_q.lock;
    assign aw_attrs_o           = pay_q.attrs;
    assign w_valid_o            = w_pend_q;
    assign w_data_o             = pay_q.data;
    assign w_strb_o             = pay_q.strb;
    assign biu_imp_bus_fault_o  = imp_q;
    assign biu_dbg_bus_fault_o  = dbgf_q;
    assign biu_strex_done_o     = sdone_q;
    assign biu_strex_fail_o     = sfail_q;

    a_slot_onehot: assert property (@(posedge clk) disable iff (!csysreset_n)
        ack |-> $onehot(stb_biu_write_slot_i));
    a_b_outstanding: assert property (@(posedge clk) disable iff (!csysreset_n)
        b_valid_i |-> out_q[b_id_i]) else $warning("write response for idle ID ignored");
endmodule

// File: tb/tb_yamin_biu_wr.sv
// tb_yamin_biu_wr: directed writes against a transaction-level model that is
// compared with the DUT every cycle, plus hand-computed literal expectations.
module tb_yamin_biu_wr;
    import yamin_biu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, priv, ns, dbg, strex, aw_ready, w_ready, b_valid;
    logic [3:0]  slot, strb;
    logic [31:0] a[4];
    logic [31:0] data;
    size_t       size;
    attr_t       attrs;
    logic [1:0]  b_id;
    bresp_t      b_resp;
    logic        ack, aw_valid, aw_lock, w_valid, imp, dbgf, sdone, sfail;
    logic [3:0]  wids, w_strb;
    logic [31:0] aw_addr, w_data;
    logic [1:0]  aw_id;
    size_t       aw_size;
    logic [2:0]  aw_prot;
    attr_t       aw_attrs;

    yamin_biu_wr dut (
        .clk                     (clk),
        .csysreset_n             (rst_n),
        .stb_biu_write_req_i     (req),
        .stb_biu_write_slot_i    (slot),
        .stb_biu_slot0_addr_i    (a[0]),
        .stb_biu_slot1_addr_i    (a[1]),
        .stb_biu_slot2_addr_i    (a[2]),
        .stb_biu_slot3_addr_i    (a[3]),
        .stb_biu_write_data_i    (data),
        .stb_biu_write_wstrb_i   (strb),
        .stb_biu_write_size_i    (size),
        .stb_biu_write_priv_i    (priv),
        .stb_biu_write_ns_attr_i (ns),
        .stb_biu_write_dbg_i     (dbg),
        .stb_biu_write_strex_i   (strex),
        .stb_biu_write_attrs_i   (attrs),
        .biu_stb_write_ack_o     (ack),
        .biu_stb_valid_wids_o    (wids),
        .aw_valid_o              (aw_valid),
        .aw_ready_i              (aw_ready),
        .aw_addr_o               (aw_addr),
        .aw_id_o                 (aw_id),
        .aw_size_o               (aw_size),
        .aw_prot_o               (aw_prot),
        .aw_lock_o               (aw_lock),
        .aw_attrs_o              (aw_attrs),
        .w_valid_o               (w_valid),
        .w_ready_i               (w_ready),
        .w_data_o                (w_data),
        .w_strb_o                (w_strb),
        .b_valid_i               (b_valid),
        .b_id_i                  (b_id),
        .b_resp_i                (b_resp),
        .biu_imp_bus_fault_o     (imp),
        .biu_dbg_bus_fault_o     (dbgf),
        .biu_strex_done_o        (sdone),
        .biu_strex_fail_o        (sfail)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: set of busy IDs with their debug/exclusive flags, one in-flight request.
    logic [3:0]  m_out = '0, m_dbg = '0, m_strex = '0;
    logic        m_aw = 0, m_w = 0, m_imp = 0, m_dbgf = 0, m_sdone = 0, m_sfail = 0, chk_en = 0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_strb = '0, m_attrs = '0;
    logic [1:0]  m_id = '0, m_size = '0;
    logic [2:0]  m_prot = '0;
    logic        m_lock = 0;

    function automatic logic model_ack();
        return req && rst_n && !(m_aw || m_w) && (m_out != 4'hF);
    endfunction

    always @(posedge clk) begin : model
        logic        acc, aw, w, err, i_f, d_f, s_d, s_f;
        logic [3:0]  o, dg, sx;
        logic [31:0] sa;
        int          fid;
        acc = model_ack();
        fid = 0;
        for (int i = 3; i >= 0; i--) if (!m_out[i]) fid = i;
        sa = '0;
        for (int i = 0; i < 4; i++) if (slot[i]) sa = a[i];
        o = m_out; dg = m_dbg; sx = m_strex;
        aw = m_aw && !aw_ready;
        w = m_w && !w_ready;
        i_f = 0; d_f = 0; s_d = 0; s_f = 0;
        err = (b_resp == SLVERR) || (b_resp == DECERR);
        if (b_valid && o[b_id]) begin
            i_f = err && !dg[b_id];
            d_f = err && dg[b_id];
            s_d = sx[b_id];
            s_f = sx[b_id] && (b_resp != EXOKAY);
            o[b_id] = 1'b0;
        end
        if (acc) begin
            o[fid] = 1'b1; dg[fid] = dbg; sx[fid] = strex; aw = 1; w = 1;
        end
        if (!rst_n) begin
            o = '0; dg = '0; sx = '0; aw = 0; w = 0; i_f = 0; d_f = 0; s_d = 0; s_f = 0;
            m_addr <= '0; m_data <= '0; m_strb <= '0; m_attrs <= '0;
            m_id <= '0; m_size <= '0; m_prot <= '0; m_lock <= 0;
        end else if (acc) begin
            m_addr <= sa; m_data <= data; m_strb <= strb; m_attrs <= attrs;
            m_id <= 2'(fid); m_size <= size; m_prot <= {1'b0, ns, priv}; m_lock <= strex;
        end
        m_out <= o; m_dbg <= dg; m_strex <= sx; m_aw <= aw; m_w <= w;
        m_imp <= i_f; m_dbgf <= d_f; m_sdone <= s_d; m_sfail <= s_f;
        cyc <= cyc + 1;
        chk_en <= 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", ack, model_ack());
            check("valid_wids", wids, m_out);
            check("aw_valid", aw_valid, m_aw);
            check("w_valid", w_valid, m_w);
            check("imp_fault", imp, m_imp);
            check("dbg_fault", dbgf, m_dbgf);
            check("strex_done", sdone, m_sdone);
            check("strex_fail", sfail, m_sfail);
            if (m_aw) begin
                check("aw_addr", aw_addr, m_addr);
                check("aw_id", aw_id, m_id);
                check("aw_size", aw_size, m_size);
                check("aw_prot", aw_prot, m_prot);
                check("aw_lock", aw_lock, m_lock);
                check("aw_attrs", aw_attrs, m_attrs);
            end
            if (m_w) begin
                check("w_data", w_data, m_data);
                check("w_strb", w_strb, m_strb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < 20 && c < 0; i++) begin
            @(negedge clk);
            if (ack) c = cyc;
            tick();
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: no ack within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic do_write(input logic [3:0] s, input logic [31:0] d, input logic dg,
                            input logic sx, output int c);
        slot = s; data = d; dbg = dg; strex = sx; req = 1;
        wait_ack(c);
        req = 0;
    endtask

    task automatic bresp(input logic [1:0] id, input bresp_t r);
        b_valid = 1; b_id = id; b_resp = r;
        tick();
        b_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, c2;
        rst_n = 0; req = 1; slot = 4'b0100; data = 32'hDEADBEEF; strb = 4'hF;
        a[0] = 32'h1000_0000; a[1] = 32'h1000_0104; a[2] = 32'h2000_0010; a[3] = 32'h3000_0FF8;
        size = yamin_pkg::SIZE_WORD; priv = 1; ns = 0; dbg = 0; strex = 0; attrs = 4'b0011;
        aw_ready = 1; w_ready = 1; b_valid = 0; b_id = 0; b_resp = OKAY;
        tick(); tick();
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_wids", wids, 0);
        check("rst_aw_valid", aw_valid, 0);
        check("rst_aw_addr", aw_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_pulses", {imp, dbgf, sdone, sfail}, 0);
        tick();
        rst_n = 1;
        c0 = cyc;
        // single write, ready high
        do_write(4'b0100, 32'hDEADBEEF, 0, 0, c1);
        check("t1_ack_cycle", c1, c0);
        @(negedge clk);
        check("t1_aw_id", aw_id, 0);
        check("t1_aw_addr", aw_addr, 32'h2000_0010);
        check("t1_w_data", w_data, 32'hDEADBEEF);
        check("t1_aw_prot", aw_prot, 3'b001);
        check("t1_wids", wids, 4'b0001);
        tick();
        bresp(0, OKAY);
        @(negedge clk);
        check("t1_wids_done", wids, 0);
        check("t1_no_pulse", {imp, dbgf, sdone, sfail}, 0);
        tick();
        // ID exhaustion
        for (int k = 0; k < 4; k++) begin
            do_write(4'b0001 << k, 32'h100 + k, 0, 0, c1);
            @(negedge clk);
            check("t2_aw_id", aw_id, k);
            tick();
        end
        @(negedge clk);
        check("t2_wids_full", wids, 4'hF);
        tick();
        slot = 4'b1000; data = 32'h0000_0555; req = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_full_no_ack", ack, 0);
            tick();
        end
        b_valid = 1; b_id = 2; b_resp = OKAY;
        @(negedge clk);
        check("t2_no_ack_on_b", ack, 0);
        tick();
        b_valid = 0;
        @(negedge clk);
        check("t2_ack_after_free", ack, 1);
        tick();
        req = 0;
        @(negedge clk);
        check("t2_reuse_id", aw_id, 2);
        check("t2_wids_refull", wids, 4'hF);
        tick();
        bresp(0, OKAY); bresp(1, OKAY); bresp(3, OKAY); bresp(2, OKAY);
        @(negedge clk);
        check("t2_wids_empty", wids, 0);
        tick();
        // decoupled channels
        w_ready = 0;
        do_write(4'b0001, 32'h1234_5678, 0, 0, c1);
        slot = 4'b1000; data = 32'hA5A5_0F0F; req = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t3_w_valid_held", w_valid, 1);
            check("t3_w_data_stable", w_data, 32'h1234_5678);
            if (k >= 2) check("t3_aw_done", aw_valid, 0);
            tick();
        end
        w_ready = 1;
        wait_ack(c2);
        req = 0;
        check("t3_next_ack_gap", c2 - c1, 6);
        bresp(0, OKAY); bresp(1, OKAY);
        tick();
        // error routing
        do_write(4'b0010, 32'h0BAD_0001, 0, 0, c1);
        tick();
        bresp(0, SLVERR);
        @(negedge clk);
        check("t4_imp_fault", imp, 1);
        check("t4_imp_not_dbg", dbgf, 0);
        tick();
        @(negedge clk);
        check("t4_imp_one_cycle", imp, 0);
        tick();
        do_write(4'b0010, 32'h0BAD_0002, 1, 0, c1);
        tick();
        bresp(0, DECERR);
        @(negedge clk);
        check("t4_dbg_fault", dbgf, 1);
        check("t4_dbg_not_imp", imp, 0);
        tick();
        // exclusive writes
        do_write(4'b0001, 32'h5555_AAAA, 0, 1, c1);
        @(negedge clk);
        check("t5_aw_lock", aw_lock, 1);
        tick();
        bresp(0, EXOKAY);
        @(negedge clk);
        check("t5_exok_done", sdone, 1);
        check("t5_exok_fail", sfail, 0);
        tick();
        do_write(4'b0001, 32'h5555_BBBB, 0, 1, c1);
        tick();
        bresp(0, OKAY);
        @(negedge clk);
        check("t5_ok_done", sdone, 1);
        check("t5_ok_fail", sfail, 1);
        tick();
        // reset mid-transaction
        do_write(4'b0001, 32'hC0DE_0001, 0, 0, c1);
        tick();
        aw_ready = 0;
        do_write(4'b0010, 32'hC0DE_0002, 0, 1, c1);
        @(negedge clk);
        check("t6_aw_pending", aw_valid, 1);
        check("t6_two_busy", wids, 4'b0011);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1; aw_ready = 1; strex = 0;
        @(negedge clk);
        check("t6_aw_cleared", aw_valid, 0);
        check("t6_w_cleared", w_valid, 0);
        check("t6_wids_cleared", wids, 0);
        tick();
        bresp(1, SLVERR);
        @(negedge clk);
        check("t6_stale_b_quiet", {imp, dbgf, sdone, sfail}, 0);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/yamin_biu_wr.md
# yamin_biu_wr

Bus-side write-request acceptor for the store-buffer-to-BIU write path. It accepts one store-buffer write request at a time, allocates one of four write IDs and drives an AXI-style AW/W channel pair. It tracks outstanding IDs until their B responses return, and reports per-ID completion and bus errors back to the store buffer and LSU. It sits inside the BIU, directly opposite the store buffer's write-request port.

## Interface
- NUM_WIDS, 4, number of write IDs; only 4 is supported, and the value is checked by an elaboration assertion.
- Reset: one clock; reset is synchronous and active-low.
- clk  in  1  core clock
- csysreset_n  in  1  synchronous active-low reset
- stb_biu_write_req_i  in  1  store buffer requests a write
- stb_biu_write_slot_i  in  4  one-hot slot selecting the address
- stb_biu_slot0..3_addr_i  in  32 each  slot addresses
- stb_biu_write_data_i / _wstrb_i  in  32 / 4  write data / byte strobes
- stb_biu_write_size_i  in  size_t  access size
- stb_biu_write_priv_i, _ns_attr_i, _dbg_i, _strex_i  in  1 each  privileged, non-secure, debug, exclusive
- stb_biu_write_attrs_i  in  attr_t  memory attributes
- biu_stb_write_ack_o  out  1  request accepted this cycle
- biu_stb_valid_wids_o  out  4  bitmap of outstanding write IDs
- aw_valid_o / aw_ready_i  out / in  1  address handshake
- aw_addr_o, aw_id_o, aw_size_o, aw_prot_o, aw_lock_o, aw_attrs_o  out  32, 2, size_t, 3, 1, attr_t  address payload
- w_valid_o / w_ready_i  out / in  1  data handshake
- w_data_o, w_strb_o  out  32, 4  data payload
- b_valid_i, b_id_i, b_resp_i  in  1, 2, bresp_t  write response (bready is tied high)
- biu_imp_bus_fault_o  out  1  pulse: error response on a non-debug write
- biu_dbg_bus_fault_o  out  1  pulse: error response on a debug write
- biu_strex_done_o, biu_strex_fail_o  out  1 each  pulse: exclusive write completed / exclusive write failed

## Operation
- **State.**
  - Holding register: hold_valid, payload, wid.
  - Per-handshake flags: aw_pend and w_pend.
  - Per-ID bitmaps: outstanding[3:0], is_dbg[3:0], is_strex[3:0].
- **Accept condition:** `can_accept = !hold_valid && (outstanding != 4'b1111)`. It depends on registered state only.
  - `ack = req && can_accept`, forced to 0 while csysreset_n is low.
- **On accept.**
  - Address is muxed from the slot address selected by the one-hot slot. A non-one-hot slot is an assertion failure.
  - Payload is captured and hold_valid, aw_pend and w_pend are set.
  - wid is the lowest-index free ID. outstanding[wid] is set; is_dbg[wid] and is_strex[wid] are set from the request.
- **Channel drive.**
  - aw_valid_o = aw_pend and w_valid_o = w_pend. Both are driven from registers.
  - Each flag clears on its own handshake. AW and W may complete in either order or in the same cycle.
  - hold_valid clears when both flags are clear, i.e. in the cycle after the last handshake.
- **Channel payload.**
  - aw_prot_o = {1'b0, ns, priv}.
  - aw_lock_o = strex.
- **On b_valid_i.**
  - outstanding[b_id] is cleared.
  - OKAY or EXOKAY: no fault.
  - SLVERR or DECERR: pulse biu_dbg_bus_fault_o if is_dbg[b_id], otherwise biu_imp_bus_fault_o.
  - If is_strex[b_id]: pulse biu_strex_done_o, and assert biu_strex_fail_o when b_resp != EXOKAY.
  - A response for a non-outstanding ID is ignored and flagged by an assertion.
- **Simultaneous events.**
  - Accept and response in the same cycle both take effect.
  - A freed ID becomes allocatable in the next cycle.
  - An accept when all IDs are busy is impossible by construction.

## Timing
- **Reset values:** all registers 0. Every output is 0: ack, valid_wids, aw_valid, w_valid, all pulses and all payloads.
- **Handshake latencies.**
  - Ack in cycle N puts aw_valid/w_valid high in cycle N+1.
  - With ready held high, handshakes occur at N+1 and hold_valid clears at N+2, so the next ack can come at N+2.
  - Peak throughput is one write every 2 cycles.
- **Response latency.**
  - biu_stb_valid_wids_o is registered: the bit rises at N+1 and falls in the cycle after b_valid_i.
  - Fault and strex pulses are registered, one cycle after b_valid_i, each one cycle wide.
- **Valid/ready rules.** aw_valid and w_valid, once high, stay high with a stable payload until ready.
- **Reset mid-operation:** pending handshakes and outstanding IDs are discarded, and no pulses fire on the reset cycle.

## Structure
- Package yamin_biu_pkg:
  - bresp_t enum: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - NUM_WIDS_C = 4.
  - Reuses attr_t and size_t from yamin_pkg.
- Sub-module yamin_biu_wid_alloc: free-bitmap lowest-index priority encoder, outputs an any_free flag and a 2-bit index.

## Test plan
- **Single write, ready high.** Req at slot 4'b0100, addr 0x2000_0010, data 0xDEADBEEF, wstrb 4'hF → ack at cycle 0; aw_id=0, aw_addr=0x2000_0010 and w_data=0xDEADBEEF at cycle 1; valid_wids=4'b0001; after B OKAY id 0, valid_wids=0 and no pulses.
- **ID exhaustion.** Four writes with b_valid withheld → IDs 0,1,2,3 allocated and valid_wids=4'hF; a 5th request is not acked until B id 2 returns, then it is acked with aw_id=2.
- **Decoupled channels.** w_ready held low 3 cycles after AW completes → w_valid and w_data stay stable; the next ack comes exactly 1 cycle after the W handshake.
- **Error routing.**
  - Non-debug write with SLVERR → one-cycle biu_imp_bus_fault_o.
  - Debug write with DECERR → biu_dbg_bus_fault_o only.
- **Exclusive writes.**
  - strex write → aw_lock=1.
  - B EXOKAY → done=1, fail=0.
  - B OKAY → done=1, fail=1.
- **Reset mid-transaction.** csysreset_n low for 1 cycle while aw_valid is high and 2 IDs are outstanding → aw_valid, w_valid and valid_wids are 0 next cycle, and a later B for an old ID produces no pulse.
